// File: rtl/cc_flag_unit_pkg.sv
// Shared encodings and types for the condition-code flag unit.
// CC_CARRY_EN adds a carry/borrow flag to the flag record.
package cc_flag_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_XOR = 4'd3
    } alu_fun_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
`ifdef CC_CARRY_EN
        logic cf;
`endif
    } cc_flags_t;

    // Architectural reset value: "zero" result, positive, no overflow.
    localparam cc_flags_t FLAGS_RST = '{zf: 1'b1, default: 1'b0};

    // EMPTY: no rollback value held; ARMED: shadow holds the pre-update flags.
    typedef enum logic {
        EMPTY = 1'b0,
        ARMED = 1'b1
    } rb_state_e;

endpackage

// File: rtl/cc_flag_unit_if.sv
// Bus between the execute stage and the flag unit.
// CF appears only when CC_CARRY_EN is defined.
interface cc_flag_unit_if #(
    parameter int W = 64
);
    logic [3:0]   alu_fun;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_e;
    logic         set_cc;
    logic         exc;
    logic         stall;
    logic         restore;
    logic         ZF;
    logic         SF;
    logic         OF;
`ifdef CC_CARRY_EN
    logic         CF;
`endif
    logic         flags_valid;
    logic [7:0]   upd_cnt;

    modport master (
        output alu_fun, alu_a, alu_b, alu_e, set_cc, exc, stall, restore,
`ifdef CC_CARRY_EN
        input  CF,
`endif
        input  ZF, SF, OF, flags_valid, upd_cnt
    );

    modport slave (
        input  alu_fun, alu_a, alu_b, alu_e, set_cc, exc, stall, restore,
`ifdef CC_CARRY_EN
        output CF,
`endif
        output ZF, SF, OF, flags_valid, upd_cnt
    );
endinterface

// File: rtl/cc_flag_calc.sv
// Combinational next-flag computation from the ALU operands and result.
// Produces the carry/borrow flag as well when CC_CARRY_EN is defined.
module cc_flag_calc
    import cc_flag_unit_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]   alu_fun,
    input  logic [W-1:0] alu_a,
    input  logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_e,
    output cc_flags_t    nflags
);

`ifdef CC_CARRY_EN
    logic [W-1:0] sum;
    assign sum = alu_a + alu_b;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        nflags    = '0;
        nflags.zf = (alu_e == '0);
        nflags.sf = alu_e[W-1];
        case (alu_fun)
            ALU_ADD: begin
                nflags.of = (alu_a[W-1] == alu_b[W-1]) && (alu_e[W-1] != alu_a[W-1]);
`ifdef CC_CARRY_EN
                nflags.cf = (sum < alu_a);
`endif
            end
            ALU_SUB: begin
                // valE = valB - valA, so overflow is judged against B's sign.
                nflags.of = (alu_a[W-1] != alu_b[W-1]) && (alu_e[W-1] != alu_b[W-1]);
`ifdef CC_CARRY_EN
                nflags.cf = (alu_b < alu_a);
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cc_flag_unit.sv
// Condition-code register with one-level rollback shadow and update counter.
// Define CC_CARRY_EN to add the CF flag.
module cc_flag_unit
    import cc_flag_unit_pkg::*;
#(
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    cc_flag_unit_if.slave bus
);

    cc_flags_t nflags;
    cc_flags_t cur_q;
    cc_flags_t shadow_q;
    rb_state_e state_q;
    rb_state_e state_d;
    logic      valid_q;
    logic [7:0] cnt_q;
    logic      commit;
    logic      rollback;

    cc_flag_calc #(.W(W)) u_calc (
        .alu_fun (bus.alu_fun),
        .alu_a   (bus.alu_a),
        .alu_b   (bus.alu_b),
        .alu_e   (bus.alu_e),
        .nflags  (nflags)
    );

    // Restore has priority over set_cc; stall freezes everything.
    assign commit   = bus.set_cc && !bus.exc && !bus.stall && !bus.restore;
    assign rollback = bus.restore && !bus.stall && (state_q == ARMED);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (commit) state_d = ARMED;
            ARMED:   if (rollback) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q    <= FLAGS_RST;
            shadow_q <= FLAGS_RST;
            valid_q  <= 1'b0;
            cnt_q    <= 8'd0;
        end else if (commit) begin
            shadow_q <= cur_q;
            cur_q    <= nflags;
            valid_q  <= 1'b1;
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        end else if (rollback) begin
            cur_q <= shadow_q;
        end
    end

    assign bus.ZF          = cur_q.zf;
    assign bus.SF          = cur_q.sf;
    assign bus.OF          = cur_q.of;
`ifdef CC_CARRY_EN
    assign bus.CF          = cur_q.cf;
`endif
    assign bus.flags_valid = valid_q;
    assign bus.upd_cnt     = cnt_q;

endmodule

// File: tb/tb_cc_flag_unit.sv
// Self-checking bench for cc_flag_unit: randomized traffic against a behavioural
// model plus directed scenarios with hand-computed expectations.
module tb_cc_flag_unit;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cc_flag_unit_if #(.W(W)) bus ();

    cc_flag_unit #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    typedef struct {
        bit zf;
        bit sf;
        bit of;
        bit cf;
    } mflags_t;

    mflags_t m_cur, m_sh;
    bit      m_sv;
    bit      m_valid;
    int      m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // Flag rules stated directly on the operand and result sign bits.
    function automatic mflags_t spec_next(input int fun, input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] e);
        mflags_t    f;
        logic [64:0] s;
        f.zf = (e == 64'd0);
        f.sf = e[63];
        f.of = 1'b0;
        f.cf = 1'b0;
        if (fun == 0) begin
            f.of = (a[63] == b[63]) && (e[63] != a[63]);
            s    = {1'b0, a} + {1'b0, b};
            f.cf = s[64];
        end else if (fun == 1) begin
            f.of = (a[63] != b[63]) && (e[63] != b[63]);
            f.cf = (b < a);
        end
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur   <= '{zf: 1'b1, sf: 1'b0, of: 1'b0, cf: 1'b0};
            m_sh    <= '{zf: 1'b1, sf: 1'b0, of: 1'b0, cf: 1'b0};
            m_sv    <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (!bus.stall) begin
            if (bus.restore) begin
                if (m_sv) begin
                    m_cur <= m_sh;
                    m_sv  <= 1'b0;
                end
            end else if (bus.set_cc && !bus.exc) begin
                m_sh    <= m_cur;
                m_cur   <= spec_next(int'(bus.alu_fun), bus.alu_a, bus.alu_b, bus.alu_e);
                m_sv    <= 1'b1;
                m_valid <= 1'b1;
                m_cnt   <= (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ZF", bus.ZF, m_cur.zf);
            check("model_SF", bus.SF, m_cur.sf);
            check("model_OF", bus.OF, m_cur.of);
`ifdef CC_CARRY_EN
            check("model_CF", bus.CF, m_cur.cf);
`endif
            check("model_valid", bus.flags_valid, m_valid);
            check("model_cnt", bus.upd_cnt, m_cnt);
        end
    end

    task automatic drive(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] e, input bit set, input bit exc, input bit stall,
                         input bit restore);
        bus.alu_fun = fun;
        bus.alu_a   = a;
        bus.alu_b   = b;
        bus.alu_e   = e;
        bus.set_cc  = set;
        bus.exc     = exc;
        bus.stall   = stall;
        bus.restore = restore;
    endtask

    task automatic step(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] e, input bit set, input bit exc, input bit stall,
                        input bit restore);
        drive(fun, a, b, e, set, exc, stall, restore);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit zf, input bit sf, input bit of,
                              input bit valid, input int cnt);
        check({tag, "_ZF"}, bus.ZF, zf);
        check({tag, "_SF"}, bus.SF, sf);
        check({tag, "_OF"}, bus.OF, of);
        check({tag, "_valid"}, bus.flags_valid, valid);
        check({tag, "_cnt"}, bus.upd_cnt, cnt);
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            3:       v = 64'h8000_0000_0000_0000;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic random_step(input bit force_commit);
        logic [3:0]  fun;
        logic [63:0] a, b, e;
        bit          set, exc, stall, restore;
        fun = 4'($urandom_range(0, 7));
        a   = rand_operand();
        b   = rand_operand();
        case (fun)
            4'd0:    e = b + a;
            4'd1:    e = b - a;
            4'd2:    e = b & a;
            default: e = b ^ a;
        endcase
        if ($urandom_range(0, 3) == 0) e = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) e = 64'd0;
        if (force_commit) begin
            set = 1'b1; exc = 1'b0; stall = 1'b0; restore = 1'b0;
        end else begin
            set     = ($urandom_range(0, 3) != 0);
            exc     = ($urandom_range(0, 9) == 0);
            stall   = ($urandom_range(0, 9) == 0);
            restore = ($urandom_range(0, 6) == 0);
        end
        step(fun, a, b, e, set, exc, stall, restore);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        repeat (5) step(4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("idle", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        step(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("add_ovf", 1'b0, 1'b1, 1'b1, 1'b1, 1);

        step(4'd1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("sub_zero", 1'b1, 1'b0, 1'b0, 1'b1, 2);
        step(4'd3, 64'd0, 64'd0, 64'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("xor", 1'b0, 1'b0, 1'b0, 1'b1, 3);
        step(4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("restore1", 1'b1, 1'b0, 1'b0, 1'b1, 3);
        step(4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("restore2", 1'b1, 1'b0, 1'b0, 1'b1, 3);

        step(4'd0, 64'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("blk_exc", 1'b1, 1'b0, 1'b0, 1'b1, 3);
        step(4'd0, 64'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("blk_stall", 1'b1, 1'b0, 1'b0, 1'b1, 3);
        step(4'd0, 64'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("blk_restore", 1'b1, 1'b0, 1'b0, 1'b1, 3);

        // Rollback is still honoured while an exception is pending.
        step(4'd2, 64'd3, 64'd1, 64'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("and_commit", 1'b0, 1'b0, 1'b0, 1'b1, 4);
        step(4'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_out("restore_exc", 1'b1, 1'b0, 1'b0, 1'b1, 4);

`ifdef CC_CARRY_EN
        step(4'd2, 64'd1, 64'd1, 64'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("cf_prior", bus.CF, 1'b0);
        step(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("cf_add_CF", bus.CF, 1'b1);
        check("cf_add_ZF", bus.ZF, 1'b1);
        check("cf_add_OF", bus.OF, 1'b0);
        step(4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("cf_restore_CF", bus.CF, 1'b0);
        check("cf_restore_ZF", bus.ZF, 1'b0);
`endif

        for (int i = 0; i < 1500; i++) random_step(1'b0);

        for (int i = 0; i < 300; i++) random_step(1'b1);
        check("sat_cnt", bus.upd_cnt, 8'd255);
        check("sat_valid", bus.flags_valid, 1'b1);

        // Reset lands between edges with stall/restore/set_cc all active.
        drive(4'd0, 64'd1, 64'd2, 64'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        expect_out("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        drive(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_out("first_commit", 1'b0, 1'b1, 1'b1, 1'b1, 1);
        step(4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("restore_rst", 1'b1, 1'b0, 1'b0, 1'b1, 1);

        for (int i = 0; i < 200; i++) random_step(1'b0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cc_flag_unit.md
CC_FLAG_UNIT -- requirements
Module: cc_flag_unit

Interface
REQ-001 Parameter: W, default 64, datapath width of ALU operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 alu_fun  input  4  ALU op of the flag-producing instruction: 0 add, 1 sub, 2 and, 3 xor; others reserved.
REQ-005 alu_a  input  W  ALU operand A (valA).
REQ-006 alu_b  input  W  ALU operand B (valB).
REQ-007 alu_e  input  W  ALU result (valE = valB op valA).
REQ-008 set_cc  input  1  request to latch new flags this cycle.
REQ-009 exc  input  1  exception present downstream; suppresses update.
REQ-010 stall  input  1  hold all state.
REQ-011 restore  input  1  roll flags back to value before last committed update.
REQ-012 ZF, SF, OF  output  1 each  registered condition flags, consumed by the condition evaluator.
REQ-013 flags_valid  output  1  high once at least one update has committed since reset.
REQ-014 upd_cnt  output  8  saturating count of committed updates.

Function
REQ-015 Next flags computed combinationally from current inputs: nZF = (alu_e == 0); nSF = alu_e[W-1].
REQ-016 nOF for add: (a[W-1] == b[W-1]) && (e[W-1] != a[W-1]).
REQ-017 nOF for sub: (a[W-1] != b[W-1]) && (e[W-1] != b[W-1]).
REQ-018 nOF = 0 for and, xor and reserved alu_fun values.
REQ-019 Commit condition: set_cc && !exc && !stall && !restore.
REQ-020 On commit: shadow <= current {ZF,SF,OF}; current <= {nZF,nSF,nOF}; shadow_valid <= 1; flags_valid <= 1; upd_cnt increments.
REQ-021 Latency: committed flags visible on outputs the cycle after the commit edge; no combinational path from inputs to outputs.
REQ-022 restore && !stall && shadow_valid: current <= shadow; shadow_valid <= 0; upd_cnt unchanged.
REQ-023 restore with shadow_valid = 0: no state change (only one level of rollback).
REQ-024 restore and set_cc in same cycle: restore wins; no commit.
REQ-025 stall = 1: all registers hold regardless of other inputs.
REQ-026 exc = 1: set_cc ignored; restore still honoured.
REQ-027 upd_cnt saturates at 255; no wrap to 0.
REQ-028 State machine, two states: EMPTY (shadow_valid = 0) and ARMED (shadow_valid = 1); EMPTY->ARMED on commit, ARMED->ARMED on commit, ARMED->EMPTY on restore.

Reset
REQ-029 While rst_n = 0: ZF = 1, SF = 0, OF = 0, shadow = {1,0,0}, shadow_valid = 0, flags_valid = 0, upd_cnt = 0.
REQ-030 Reset asserted mid-operation overrides stall, restore and set_cc immediately; first commit is possible on the first rising edge with rst_n = 1.

Configuration
REQ-031 Macro CC_CARRY_EN: when defined, adds output CF (1 bit); CF = carry out of bit W-1 for add, borrow for sub, 0 otherwise; CF is shadowed, restored and reset (to 0) with the other flags.
REQ-032 Without CC_CARRY_EN: no CF port; CF logic is absent.

Structure
REQ-033 Shared package holds the alu_fun encodings (ADD, SUB, AND, XOR) and the flag-reset constant {ZF=1,SF=0,OF=0}.
REQ-034 One sub-module, cc_flag_calc: purely combinational computation of nZF/nSF/nOF (and nCF under CC_CARRY_EN); the register, shadow, counter and state live in cc_flag_unit.

Verification
REQ-035 Reset -> ZF=1, SF=0, OF=0, flags_valid=0, upd_cnt=0; release, set_cc=0 for 5 cycles -> unchanged.
REQ-036 add a=0x7FFF_FFFF_FFFF_FFFF, b=1, e=0x8000_0000_0000_0000, set_cc=1 -> next cycle ZF=0, SF=1, OF=1, flags_valid=1, upd_cnt=1.
REQ-037 sub a=5, b=5, e=0 committed, then xor e=0x10 committed, then restore -> flags return to ZF=1, SF=0, OF=0; second restore -> no change.
REQ-038 set_cc=1 with exc=1, then with stall=1, then with restore=1 (shadow empty) -> flags and upd_cnt unchanged in all three cycles.
REQ-039 300 consecutive commits -> upd_cnt = 255; assert rst_n=0 mid-sequence with stall=1 -> all outputs at reset values immediately.
REQ-040 With CC_CARRY_EN: add a=0xFFFF_FFFF_FFFF_FFFF, b=1, e=0 -> CF=1, ZF=1, OF=0; restore -> CF returns to prior value.
